// File: rtl/handshake_sink.sv
`default_nettype none
// ============================================================================
// Module   : handshake_sink
// Purpose  : Receiving end of a 4-phase bundled-data channel whose
//            data is tagged by a dual-rail timing-error code. Accepted
//            items are queued in a small FIFO for a synchronous consumer.
//            The channel signals are asynchronous to clk. They pass
//            through a 2-flop synchronizer. A three-state controller
//            (IDLE/CAPT/WAITLO) then performs exactly one FIFO write per
//            request.
// Ports    :
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-low reset
//   Rreq       in   4-phase request (asynchronous)
//   Rdata      in   DW-bit bundled data, stable while Rreq=1 and Rack=0
//   Err1/Err0  in   dual-rail error code: 10 = error, 01 = clean,
//                   00 = not yet valid, 11 = illegal
//   Rack       out  registered 4-phase acknowledge
//   out_data   out  FIFO head data (0 while empty)
//   out_err    out  FIFO head error tag (0 while empty)
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer pops the head when out_valid is high
//   err_count  out  saturating count of captured error-tagged items
//   proto_err  out  sticky: an illegal 11 code was seen with Rreq high
// Revision : 1.0  initial release
// ============================================================================
module handshake_sink #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Rreq,
  input  logic [DW-1:0] Rdata,
  input  logic          Err1,
  input  logic          Err0,
  output logic          Rack,
  output logic [DW-1:0] out_data,
  output logic          out_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    err_count,
  output logic          proto_err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int               c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};
  localparam logic [7:0]       c_ERR_MAX = 8'hFF;

  // --------------------------------------------------------------------------
  // Controller states
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAPT   = 2'd1,
    WAITLO = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [2:0]    r_sync1;        // first synchronizer stage {Rreq,Err1,Err0}
  logic [2:0]    r_sync2;        // second synchronizer stage
  logic          w_req_s;
  logic          w_err1_s;
  logic          w_err0_s;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rack;
  logic          w_rack_nxt;
  logic          r_proto_err;
  logic          w_proto_nxt;
  logic          r_err_lat;      // error rail value that qualified the capture
  logic          w_err_lat_nxt;
  logic          w_push;
  logic [7:0]    r_err_count;

  logic [DW:0]   r_mem [DEPTH];  // {err, data}
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr_en;
  logic [DW:0]   w_head;

  // --------------------------------------------------------------------------
  // 2-flop synchronizer for the asynchronous channel signals
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {Rreq, Err1, Err0};
      r_sync2 <= r_sync1;
    end
  end

  assign w_req_s  = r_sync2[2];
  assign w_err1_s = r_sync2[1];
  assign w_err0_s = r_sync2[0];

  // --------------------------------------------------------------------------
  // Controller: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rack      <= 1'b0;
      r_proto_err <= 1'b0;
      r_err_lat   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rack      <= w_rack_nxt;
      r_proto_err <= w_proto_nxt;
      r_err_lat   <= w_err_lat_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Controller: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_rack_nxt    = r_rack;
    w_proto_nxt   = r_proto_err;
    w_err_lat_nxt = r_err_lat;
    w_push        = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_req_s) begin
          if (w_err1_s && w_err0_s) begin
            // Illegal code: flag it and keep waiting for a legal one.
            w_proto_nxt = 1'b1;
          end else if ((w_err1_s ^ w_err0_s) && !w_full) begin
            // Hold on to the rail value that qualified this capture so a
            // late rail change cannot alter the stored tag.
            w_state_nxt   = CAPT;
            w_err_lat_nxt = w_err1_s;
          end
        end
      end

      CAPT: begin
        // The slot was free on entry and only this state pushes, so the
        // write always fits.
        w_push      = 1'b1;
        w_rack_nxt  = 1'b1;
        w_state_nxt = WAITLO;
      end

      WAITLO: begin
        // Stay here however long Rreq is held: one write per 4-phase cycle.
        if (!w_req_s) begin
          w_rack_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_rack_nxt  = 1'b0;
      end
    endcase
  end

  assign Rack      = r_rack;
  assign proto_err = r_proto_err;

  // --------------------------------------------------------------------------
  // Saturating error counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_count <= '0;
    end else if (w_push && r_err_lat && (r_err_count != c_ERR_MAX)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;

  // --------------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit to tell full from empty
  // --------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_pop   = !w_empty && out_ready;
  // A pop in the same cycle frees the slot, so push-while-full is allowed.
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Storage needs no reset: an entry is only visible after it was written.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {r_err_lat, Rdata};
    end
  end

  // The head is forced to zero while empty so reset and drained states show
  // clean outputs instead of stale storage.
  assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];
  assign out_valid = !w_empty;
  assign out_data  = w_head[DW-1:0];
  assign out_err   = w_head[DW];

endmodule
`default_nettype wire

// File: tb/tb_handshake_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_sink
// Purpose  : Self-checking bench for handshake_sink. It drives 4-phase
//            requests and keeps a queue of expected FIFO items. Every pop
//            is compared against the head of that queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_handshake_sink;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          Rreq      = 1'b0;
  logic [DW-1:0] Rdata     = '0;
  logic          Err1      = 1'b0;
  logic          Err0      = 1'b0;
  logic          out_ready = 1'b0;
  logic          Rack;
  logic [DW-1:0] out_data;
  logic          out_err;
  logic          out_valid;
  logic [7:0]    err_count;
  logic          proto_err;

  int            n_chk  = 0;
  int            n_fail = 0;
  int            exp_ec = 0;
  logic [8:0]    sb [$];

  typedef struct {
    logic [7:0] data;
    logic       e1;
    logic       e0;
    logic [7:0] exp_data;
    logic       exp_err;
    int         hold;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  handshake_sink #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .Rreq      (Rreq),
    .Rdata     (Rdata),
    .Err1      (Err1),
    .Err0      (Err0),
    .Rack      (Rack),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count),
    .proto_err (proto_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Pops happen on the next rising edge; sample on the falling edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", 32'(out_valid), 32'd0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("pop_data", 32'(out_data), 32'(e[7:0]));
        chk("pop_err", 32'(out_err), 32'(e[8]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_item(input logic [7:0] d, input logic e1);
    sb.push_back({e1, d});
    if (e1 && exp_ec < 255) exp_ec++;
  endtask

  task automatic wait_rack(input logic val, input int max, output int edges);
    edges = 0;
    while (Rack !== val && edges < max) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk(val ? "rack_rise_seen" : "rack_fall_seen", 32'(Rack), 32'(val));
  endtask

  task automatic do_hs(input logic [7:0] d, input logic e1, input logic e0,
                       input int hold, output int lup, output int ldn);
    Rdata = d;
    Err1  = e1;
    Err0  = e0;
    Rreq  = 1'b1;
    expect_item(d, e1);
    wait_rack(1'b1, 40, lup);
    step(hold);
    Rreq = 1'b0;
    wait_rack(1'b0, 40, ldn);
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lu;
    int         ld;
    logic [7:0] rd;

    vecs[0] = '{data:8'hA5, e1:1'b0, e0:1'b1, exp_data:8'hA5, exp_err:1'b0, hold:0};
    vecs[1] = '{data:8'h5A, e1:1'b1, e0:1'b0, exp_data:8'h5A, exp_err:1'b1, hold:3};
    vecs[2] = '{data:8'h00, e1:1'b0, e0:1'b1, exp_data:8'h00, exp_err:1'b0, hold:1};
    vecs[3] = '{data:8'hFF, e1:1'b1, e0:1'b0, exp_data:8'hFF, exp_err:1'b1, hold:20};
    vecs[4] = '{data:8'h81, e1:1'b0, e0:1'b1, exp_data:8'h81, exp_err:1'b0, hold:7};
    vecs[5] = '{data:8'h7E, e1:1'b1, e0:1'b0, exp_data:8'h7E, exp_err:1'b1, hold:0};

    // ---------------- reset values ----------------
    step(3);
    chk("rst_rack", 32'(Rack), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_proto", 32'(proto_err), 32'd0);
    rst = 1'b1;

    // ---------------- first item, latencies ----------------
    do_hs(8'hA5, 1'b0, 1'b1, 0, lu, ld);
    chk("rise_latency", 32'(lu), 32'd4);
    chk("fall_latency", 32'(ld), 32'd3);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", 32'(out_data), 32'hA5);
    chk("first_err", 32'(out_err), 32'd0);
    pop1();
    step(1);

    // ---------------- table-driven items ----------------
    for (int i = 0; i < 6; i++) begin
      do_hs(vecs[i].data, vecs[i].e1, vecs[i].e0, vecs[i].hold, lu, ld);
      chk("vec_rise_lat", 32'(lu), 32'd4);
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk("vec_data", 32'(out_data), 32'(vecs[i].exp_data));
      chk("vec_err", 32'(out_err), 32'(vecs[i].exp_err));
      chk("vec_errcnt", 32'(err_count), 32'(exp_ec));
      pop1();
      step(1);
      chk("vec_drained", 32'(out_valid), 32'd0);
    end

    // ---------------- rails 00 stall ----------------
    Rdata = 8'h44; Err1 = 1'b0; Err0 = 1'b0; Rreq = 1'b1;
    step(10);
    chk("null_rack", 32'(Rack), 32'd0);
    chk("null_valid", 32'(out_valid), 32'd0);
    chk("null_proto", 32'(proto_err), 32'd0);
    Err0 = 1'b1;
    expect_item(8'h44, 1'b0);
    wait_rack(1'b1, 20, lu);
    Rreq = 1'b0;
    wait_rack(1'b0, 20, ld);
    pop1();
    step(1);

    // ---------------- full FIFO stall and refill ----------------
    for (int i = 0; i < 4; i++) begin
      do_hs(8'(8'h10 + i), 1'b0, 1'b1, 0, lu, ld);
    end
    chk("full_head", 32'(out_data), 32'h10);
    Rdata = 8'h14; Err1 = 1'b0; Err0 = 1'b1; Rreq = 1'b1;
    expect_item(8'h14, 1'b0);
    step(10);
    chk("full_stall_rack", 32'(Rack), 32'd0);
    pop1();
    wait_rack(1'b1, 20, lu);
    chk("refill_lat", 32'(lu), 32'd2);
    Rreq = 1'b0;
    wait_rack(1'b0, 20, ld);
    chk("head_after_pop", 32'(out_data), 32'h11);
    // Occupancy is back at four: a further request must stall again.
    Rdata = 8'h15; Rreq = 1'b1;
    expect_item(8'h15, 1'b0);
    step(8);
    chk("full_again_rack", 32'(Rack), 32'd0);
    // Streaming consumer: the capture edge also pops (push+pop together).
    out_ready = 1'b1;
    wait_rack(1'b1, 20, lu);
    chk("stream_refill_lat", 32'(lu), 32'd3);
    Rreq = 1'b0;
    wait_rack(1'b0, 20, ld);
    step(10);
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    // ---------------- reset in WAITLO with two entries ----------------
    do_hs(8'h21, 1'b0, 1'b1, 0, lu, ld);
    Rdata = 8'h22; Err1 = 1'b0; Err0 = 1'b1; Rreq = 1'b1;
    expect_item(8'h22, 1'b0);
    wait_rack(1'b1, 20, lu);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_rack", 32'(Rack), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    sb.delete();
    exp_ec = 0;
    step(3);
    Rdata = 8'h33;
    rst = 1'b1;
    expect_item(8'h33, 1'b0);
    wait_rack(1'b1, 20, lu);
    chk("rereq_lat", 32'(lu), 32'd4);
    Rreq = 1'b0;
    wait_rack(1'b0, 20, ld);
    chk("rereq_data", 32'(out_data), 32'h33);
    pop1();
    step(1);

    // ---------------- error counting and saturation ----------------
    do_hs(8'h3C, 1'b1, 1'b0, 0, lu, ld);
    chk("err_item_err", 32'(out_err), 32'd1);
    chk("err_item_data", 32'(out_data), 32'h3C);
    chk("err_count_one", 32'(err_count), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      rd = 8'($urandom_range(0, 255));
      do_hs(rd, 1'b1, 1'b0, 0, lu, ld);
    end
    step(3);
    out_ready = 1'b0;
    chk("err_count_sat", 32'(err_count), 32'd255);
    chk("err_model_sat", 32'(err_count), 32'(exp_ec));

    // ---------------- illegal 11 code ----------------
    Rdata = 8'h99; Err1 = 1'b1; Err0 = 1'b1; Rreq = 1'b1;
    step(10);
    chk("proto_set", 32'(proto_err), 32'd1);
    chk("proto_rack", 32'(Rack), 32'd0);
    chk("proto_nowrite", 32'(out_valid), 32'd0);
    Err1 = 1'b0;
    expect_item(8'h99, 1'b0);
    wait_rack(1'b1, 20, lu);
    chk("proto_sticky", 32'(proto_err), 32'd1);
    Rreq = 1'b0;
    wait_rack(1'b0, 20, ld);
    chk("proto_cap_data", 32'(out_data), 32'h99);
    chk("proto_cap_err", 32'(out_err), 32'd0);
    pop1();
    step(2);
    chk("final_valid", 32'(out_valid), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    // ---------------- reset clears sticky state ----------------
    rst = 1'b0;
    step(2);
    chk("rst2_proto", 32'(proto_err), 32'd0);
    chk("rst2_errcnt", 32'(err_count), 32'd0);
    rst = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/handshake_sink.md
HANDSHAKE_SINK -- requirements
Module: handshake_sink

Interface
REQ-001: Parameter DW, default 8, width of the bundled data word.
REQ-002: Parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-003: clk  input  1  single clock; all state changes on its rising edge.
REQ-004: rst  input  1  reset, asynchronous and active-low; the block is held in reset while rst=0.
REQ-005: Rreq  input  1  4-phase request from the upstream controller; asynchronous to clk.
REQ-006: Rdata  input  DW  bundled data; stable from Rreq rise until Rack rise.
REQ-007: Err1  input  1  dual-rail error rail; 1 = the item carries a timing error.
REQ-008: Err0  input  1  dual-rail error rail; 1 = the item is clean.
REQ-009: Rack  output  1  4-phase acknowledge to upstream; registered.
REQ-010: out_data  output  DW  FIFO head data.
REQ-011: out_err  output  1  error tag of the FIFO head.
REQ-012: out_valid  output  1  FIFO non-empty.
REQ-013: out_ready  input  1  consumer accepts the head.
REQ-014: err_count  output  8  saturating count of accepted items tagged as errors.
REQ-015: proto_err  output  1  sticky flag for an illegal dual-rail code.

Function
REQ-016: Rreq, Err1 and Err0 SHALL each pass through a 2-flop synchronizer before any use.
REQ-017: The FSM SHALL have three states: IDLE, CAPT and WAITLO.
REQ-018: IDLE -> CAPT SHALL occur when all three hold:
- synchronized Rreq=1
- FIFO not full
- synchronized {Err1,Err0} is 10 or 01
REQ-019: In CAPT, the block SHALL write {Err1,Rdata} into the FIFO, set Rack=1 and go to WAITLO in the same cycle.
REQ-020: WAITLO -> IDLE SHALL occur when synchronized Rreq=0; Rack SHALL clear on that transition.
REQ-021: Latency from Rreq rise to Rack rise SHALL be exactly 4 clk edges with the FIFO not full and rails valid: 2 synchronizer, 1 IDLE->CAPT, 1 CAPT.
REQ-022: Latency from Rreq fall to Rack fall SHALL be 3 clk edges.
REQ-023: {Err1,Err0}=00 in IDLE SHALL stall, with no capture and no Rack.
REQ-024: {Err1,Err0}=11 in IDLE with Rreq=1 SHALL set proto_err and stall; proto_err clears only on reset.
REQ-025: FIFO full in IDLE SHALL stall the capture; capture SHALL proceed in the first cycle a slot is free.
REQ-026: Exactly one FIFO write SHALL occur per 4-phase cycle, regardless of how long Rreq stays high.
REQ-027: The FIFO SHALL be first-in first-out.
REQ-028: out_data and out_err SHALL present the head entry whenever out_valid=1.
REQ-029: A pop SHALL occur on out_valid & out_ready.
REQ-030: A simultaneous push and pop SHALL be legal in any occupancy, including full, with the count unchanged.
REQ-031: Pointers SHALL wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit or an occupancy counter.
REQ-032: err_count SHALL increment on each CAPT with Err1=1 and saturate at 255.

Reset
REQ-033: While rst=0, the block SHALL hold:
- FSM in IDLE, Rack=0, FIFO empty, out_valid=0
- out_data=0, out_err=0, err_count=0, proto_err=0
- all synchronizer flops 0
REQ-034: Reset asserted mid-handshake SHALL drop Rack immediately (asynchronously) and discard all FIFO contents.
REQ-035: After reset release, a still-high Rreq SHALL be treated as a new request.

Verification
REQ-036: rst=0 then released; Rreq=1, Rdata=0xA5, Err0=1 -> Rack rises on the 4th edge; out_valid=1, out_data=0xA5, out_err=0.
REQ-037: Four items with out_ready=0 (DEPTH=4), fifth Rreq=1 -> Rack stays 0; one pop -> Rack rises 2 edges later; order preserved.
REQ-038: Item with Err1=1 -> out_err=1 and err_count=1; 300 error items -> err_count=255.
REQ-039: Rails 11 with Rreq=1 -> proto_err=1, no write, Rack=0; rails then 01 -> capture proceeds and proto_err stays 1.
REQ-040: rst pulsed low while in WAITLO with 2 entries -> Rack=0 and out_valid=0 immediately.
REQ-041: Full FIFO with push and pop in the same cycle -> occupancy stays 4 and the head advances correctly.
